// File: rtl/transpose_pingpong_ram.sv
// Double-buffered N x N block RAM: one bank fills row-major while the other
// drains column-major (TRANSPOSE=1) or row-major (TRANSPOSE=0).
module transpose_pingpong_ram #(
    parameter int DATA_W    = 8,
    parameter int N         = 8,
    parameter int TRANSPOSE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int L     = $clog2(N);
    localparam int CW    = 2 * L;
    localparam int AW    = CW + 1;
    localparam int DEPTH = 2 * N * N;
    localparam logic [CW-1:0] CNT_LAST = '1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic          wr_bank, rd_bank;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic [1:0]    full;
    logic [1:0]    full_set, full_clr;
    logic          wr_fire, rd_fire;
    logic          wr_last, rd_last;
    logic [AW-1:0] wr_addr, rd_addr;

    assign in_ready = !full[wr_bank];
    assign wr_fire  = in_valid && in_ready;
    assign rd_fire  = full[rd_bank] && (!out_valid || out_ready);
    assign wr_last  = wr_fire && (wr_cnt == CNT_LAST);
    assign rd_last  = rd_fire && (rd_cnt == CNT_LAST);

    assign wr_addr = {wr_bank, wr_cnt};
    // Swapping the hi/lo halves of the read counter walks the block by column.
    assign rd_addr = (TRANSPOSE != 0) ? {rd_bank, rd_cnt[L-1:0], rd_cnt[CW-1:L]}
                                      : {rd_bank, rd_cnt};

    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (wr_last) full_set[wr_bank] = 1'b1;
        if (rd_last) full_clr[rd_bank] = 1'b1;
    end

    // NOTE: the storage array has no reset; the full flags alone decide which words are live.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= in_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            full      <= 2'b00;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_last) rd_bank <= ~rd_bank;
            end
            // Set and clear never hit the same bank: a write needs !full, a read needs full.
            full <= (full | full_set) & ~full_clr;
            if (rd_fire) begin
                out_data  <= mem[rd_addr];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_transpose_pingpong_ram.sv
// Directed bench for transpose_pingpong_ram: default 8x8 transpose instance
// with a block-transpose scoreboard, plus a 4x4 12-bit row-major instance.
module tb_transpose_pingpong_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [11:0] in_data2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [11:0] out_data2;

    int checks = 0;
    int errors = 0;

    logic [7:0] blk [64];
    int         wcount   = 0;
    int         cons_cnt = 0;
    logic       last_acc = 1'b0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    transpose_pingpong_ram dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    transpose_pingpong_ram #(.DATA_W(12), .N(4), .TRANSPOSE(0)) dut_fifo (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
    );

    task automatic clear_model();
        exp_q.delete();
        wcount   = 0;
        cons_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
    endtask

    // One cycle: drive, score the handshakes that happen at the coming edge, advance.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic [7:0] e;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        last_acc  = in_valid && in_ready;
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: out_data=%0d consumed with nothing expected", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL scoreboard_order: item %0d out_data=%0d expected %0d", cons_cnt, out_data, e);
                end
            end
            cons_cnt++;
        end
        if (last_acc) begin
            blk[wcount] = d;
            wcount++;
            if (wcount == 64) begin
                for (int c = 0; c < 8; c++)
                    for (int rr = 0; rr < 8; rr++)
                        exp_q.push_back(blk[rr*8 + c]);
                wcount = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 1000) begin
            step(1'b0, 8'd0, 1'b1);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d samples left, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%0d expected 1/0/0",
                     in_ready, out_valid, out_data);
        end
        for (int i = 0; i < 64; i++) step(1'b1, 8'(100 + i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(200 + i), 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd100) begin
            errors++;
            $display("FAIL reset_prefill: out_valid=%b out_data=%0d expected 1/100", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b out_data=%0d in_ready=%b expected 0/0/1",
                     out_valid, out_data, in_ready);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b1);
        drain("reset_fresh");
        checks++;
        if (cons_cnt != 64) begin
            errors++;
            $display("FAIL reset_fresh_count: consumed %0d expected 64", cons_cnt);
        end
    endtask

    task automatic test_single_block();
        int bubbles = 0;
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: out_valid=%b one cycle after last sample, expected 0", out_valid);
        end
        step(1'b0, 8'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL single_latency: out_valid=%b out_data=%0d two cycles after last sample, expected 1/0",
                     out_valid, out_data);
        end
        step(1'b0, 8'd0, 1'b1);
        checks++;
        if (out_data !== 8'd8) begin
            errors++;
            $display("FAIL single_second: out_data=%0d expected 8", out_data);
        end
        while (exp_q.size() > 0 && bubbles < 100) begin
            if (!out_valid) bubbles++;
            step(1'b0, 8'd0, 1'b1);
        end
        checks++;
        if (bubbles != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_contiguous: bubbles=%0d left=%0d expected 0/0", bubbles, exp_q.size());
        end
    endtask

    task automatic test_fifo_mode();
        int k = 0;
        int bad = 0;
        out_ready2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid2 = 1'b1;
            in_data2  = 12'hA00 + 12'(i);
            if (!in_ready2) bad++;
            @(posedge clk);
            #1;
        end
        in_valid2 = 1'b0;
        for (int c = 0; c < 40 && k < 16; c++) begin
            if (out_valid2) begin
                checks++;
                if (out_data2 !== 12'hA00 + 12'(k)) begin
                    errors++;
                    $display("FAIL fifo_order: item %0d out_data=%0h expected %0h", k, out_data2, 12'hA00 + 12'(k));
                end
                k++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (k != 16 || bad != 0) begin
            errors++;
            $display("FAIL fifo_count: received %0d expected 16, ready drops %0d expected 0", k, bad);
        end
    endtask

    task automatic test_back_to_back();
        int drops = 0;
        int bubbles = 0;
        logic seen = 1'b0;
        do_reset();
        for (int i = 0; i < 192; i++) begin
            if (!in_ready) drops++;
            if (out_valid) seen = 1'b1;
            else if (seen && cons_cnt < 192) bubbles++;
            step(1'b1, 8'(i), 1'b1);
        end
        for (int g = 0; g < 300 && cons_cnt < 192; g++) begin
            if (out_valid) seen = 1'b1;
            else if (seen) bubbles++;
            step(1'b0, 8'd0, 1'b1);
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL b2b_in_ready: in_ready low %0d cycles expected 0", drops);
        end
        checks++;
        if (bubbles != 0 || cons_cnt != 192) begin
            errors++;
            $display("FAIL b2b_bubbles: bubbles=%0d consumed=%0d expected 0/192", bubbles, cons_cnt);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int guard = 0;
        int unstable = 0;
        do_reset();
        while (in_ready && guard < 300) begin
            step(1'b1, 8'(acc), 1'b0);
            if (last_acc) acc++;
            guard++;
        end
        checks++;
        if (acc != 128 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepted: accepted %0d in_ready=%b expected 128/0", acc, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'd0 || in_ready !== 1'b0) unstable++;
            step(1'b1, 8'hEE, 1'b0);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d stall cycles with out_valid/out_data/in_ready != 1/0/0", unstable);
        end
        drain("bp");
        checks++;
        if (in_ready !== 1'b1 || cons_cnt != 128) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b consumed=%0d expected 1/128", in_ready, cons_cnt);
        end
    endtask

    task automatic test_random();
        int fed = 0;
        int guard = 0;
        logic v, r;
        do_reset();
        while (cons_cnt < 1280 && guard < 20000) begin
            v = (fed < 1280) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            step(v, 8'($urandom), r);
            if (last_acc) fed++;
            guard++;
        end
        checks++;
        if (cons_cnt != 1280 || exp_q.size() != 0 || wcount != 0) begin
            errors++;
            $display("FAIL random_complete: consumed=%0d left=%0d partial=%0d expected 1280/0/0",
                     cons_cnt, exp_q.size(), wcount);
        end
        step(1'b0, 8'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL random_idle: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_fifo_mode();
        test_back_to_back();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/transpose_pingpong_ram.md
# transpose_pingpong_ram

Double-buffered block RAM that accepts N×N blocks of samples in row-major order and returns each block in column-major order, or in row-major order when transposition is disabled. It sits between the row and column passes of the FDCT in the JPEG encoder. It is the parametrised successor of the fixed 8-bit × 128 single-port RAM, with two 64-entry banks in the default configuration. One bank fills while the other drains, and valid/ready handshakes are provided on both sides.

## Interface
- DATA_W, default 8: sample width in bits.
- N, default 8: block dimension; a power of two, at least 2. Each bank holds N*N words; total depth is 2*N*N.
- TRANSPOSE, default 1: 1 reads each block column-major (transpose); 0 reads it row-major (plain FIFO of blocks).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a valid sample.
- in_ready  out  1  the block can accept a sample this cycle.
- in_data  in  DATA_W  input sample, row-major within a block.
- out_valid  out  1  out_data holds a valid sample.
- out_ready  in  1  the consumer accepts out_data this cycle.
- out_data  out  DATA_W  output sample, registered.

## Operation
- Storage: a memory of 2*N*N × DATA_W words, split into bank 0 and bank 1.
  - One write port and one synchronous read port; read data is registered.
- Let L = log2(N).
- State registers:
  - wr_bank (1 bit), wr_cnt (2L bits).
  - rd_bank (1 bit), rd_cnt (2L bits).
  - full[1:0]: one flag per bank.
  - out_valid.
- in_ready = !full[wr_bank].
- Write fires when in_valid && in_ready.
  - Address = {wr_bank, wr_cnt}.
  - wr_cnt increments on each write.
  - On the write with wr_cnt == N*N-1: wr_cnt wraps to 0, full[wr_bank] is set, and wr_bank toggles.
- Read issue fires when full[rd_bank] && (!out_valid || out_ready).
  - rd_cnt is split into {hi, lo}, each L bits.
  - Read address with TRANSPOSE=1: {rd_bank, lo, hi}. With TRANSPOSE=0: {rd_bank, hi, lo}.
  - On the issue with rd_cnt == N*N-1: rd_cnt wraps to 0, full[rd_bank] clears, and rd_bank toggles.
- Output register:
  - On a read issue: out_data loads the memory word and out_valid is set.
  - Else if out_ready: out_valid clears.
  - While out_valid && !out_ready, out_data and out_valid hold stable.
- Simultaneous events:
  - A write-completion and a read-completion in the same cycle always target different banks, because a write needs !full and a read needs full. Both take effect.
  - Read and write to different banks in the same cycle never conflict.
- A bank is released at its last read issue. The writer may overwrite it from the next cycle, since the last word is already in the output register.

## Timing
- Reset values: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full=2'b00, out_valid=0, out_data=0. in_ready=1 during and after reset.
- Latency: last sample of a block accepted in cycle t, full set at the end of t, first read issued in t+1, first out_valid in t+2.
- Throughput: one sample per cycle on each side. With out_ready held at 1, a continuous input stream never sees in_ready fall.
- Backpressure: with out_ready=0, at most 2*N*N samples are accepted before in_ready falls (N*N with one block already held in the output path).
- Reset mid-block: any partial block and all buffered blocks are discarded, and all state returns to the reset values immediately.

## Test plan
- Reset: assert rst_n=0 mid-stream -> out_valid=0, out_data=0 and in_ready=1 immediately. After release, the next input starts a fresh block at wr_cnt 0.
- Single block, defaults: stream 0..63 with out_ready=1 -> out_valid rises 2 cycles after sample 63 is accepted. Outputs follow 0,8,16,…,56,1,9,…,63, each 64 consecutive cycles.
- TRANSPOSE=0, N=4, DATA_W=12: stream 0..15 -> outputs 0..15 in order.
- Back-to-back: 3 blocks of values 0..191, continuous, out_ready=1 -> in_ready stays 1 throughout. The output is the transpose of each block with no bubbles between blocks.
- Backpressure: out_ready=0 while streaming -> 128 samples accepted, then in_ready=0. out_data=0 is held stable with out_valid=1. After out_ready=1, all samples drain in transposed order and in_ready returns.
- Random out_ready toggling with random in_valid over 20 blocks -> a scoreboard confirms no sample is lost, duplicated or reordered relative to the per-block transpose.
